hazard_scoreboard: RTL and testbench

// - Producer side of the hazard interface in the 5-stage MIPS pipeline: tracks every in-flight register write

---
 rtl/hazard_scoreboard.sv | 74 +++++++
 tb/tb_hazard_scoreboard.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Producer side of the pipeline hazard interface: tracks in-flight register writes in the E/M/W slots
// and exports pending-write flags and saturating stall/flush event counters.
module hazard_scoreboard #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned TAG_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validD,
    input  logic             regwriteD,
    input  logic             memtoregD,
    input  logic [TAG_W-1:0] writeregD,
    input  logic             stallD,
    input  logic             flushE,
    output logic             regwriteE,
    output logic             regwriteM,
    output logic             regwriteW,
    output logic             memtoregE,
    output logic             memtoregM,
    output logic [TAG_W-1:0] writeregE,
    output logic [TAG_W-1:0] writeregM,
    output logic [TAG_W-1:0] writeregW,
    output logic [NREG-1:0]  pending,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic takeD;

    // A stall always means E gets a bubble; dead writes (r0 or no regwrite) are normalised to bubbles too.
    assign takeD = validD && regwriteD && !flushE && !stallD && (writeregD != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwriteE <= 1'b0;
            memtoregE <= 1'b0;
            writeregE <= '0;
            regwriteM <= 1'b0;
            memtoregM <= 1'b0;
            writeregM <= '0;
            regwriteW <= 1'b0;
            writeregW <= '0;
        end else begin
            regwriteE <= takeD;
            memtoregE <= takeD && memtoregD;
            writeregE <= takeD ? writeregD : '0;
            regwriteM <= regwriteE;
            memtoregM <= memtoregE;
            writeregM <= writeregE;
            regwriteW <= regwriteM;
            writeregW <= writeregM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallD && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flushE && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        pending = '0;
        if (regwriteE) pending[writeregE] = 1'b1;
        if (regwriteM) pending[writeregM] = 1'b1;
        if (regwriteW) pending[writeregW] = 1'b1;
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: table of decode vectors with hand-computed E-slot results, queued so
// M/W/pending expectations follow the pipeline, plus hand sequences for timing and saturation.
module tb_hazard_scoreboard;

    typedef struct {
        logic       valid;
        logic       rw;
        logic       mtr;
        logic [4:0] wr;
        logic       stall;
        logic       flush;
        logic       eRw;
        logic       eMtr;
        logic [4:0] eTag;
    } vec_t;

    typedef struct {
        logic       rw;
        logic       mtr;
        logic [4:0] tag;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        validD, regwriteD, memtoregD, stallD, flushE;
    logic [4:0]  writeregD;
    logic        regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic [4:0]  writeregE, writeregM, writeregW;
    logic [31:0] pending;
    logic [15:0] stall_cnt, flush_cnt;

    int unsigned total = 0;
    int unsigned bad = 0;
    slot_t       expQ[$];
    logic [15:0] expStall, expFlush;
    vec_t        vecs[$];

    hazard_scoreboard #(.NREG(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .validD(validD), .regwriteD(regwriteD), .memtoregD(memtoregD), .writeregD(writeregD),
        .stallD(stallD), .flushE(flushE),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .pending(pending), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearModel();
        slot_t b;
        b.rw = 1'b0; b.mtr = 1'b0; b.tag = '0;
        expQ = {b, b, b};
        expStall = '0;
        expFlush = '0;
    endtask

    task automatic checkAll();
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 3; i++) if (expQ[i].rw) p[expQ[i].tag] = 1'b1;
        p[0] = 1'b0;
        check("regwriteE", 32'(regwriteE), 32'(expQ[0].rw));
        check("memtoregE", 32'(memtoregE), 32'(expQ[0].mtr));
        check("writeregE", 32'(writeregE), 32'(expQ[0].tag));
        check("regwriteM", 32'(regwriteM), 32'(expQ[1].rw));
        check("memtoregM", 32'(memtoregM), 32'(expQ[1].mtr));
        check("writeregM", 32'(writeregM), 32'(expQ[1].tag));
        check("regwriteW", 32'(regwriteW), 32'(expQ[2].rw));
        check("writeregW", 32'(writeregW), 32'(expQ[2].tag));
        check("pending", pending, p);
        check("stall_cnt", 32'(stall_cnt), 32'(expStall));
        check("flush_cnt", 32'(flush_cnt), 32'(expFlush));
    endtask

    task automatic step(input vec_t v);
        slot_t s;
        validD = v.valid; regwriteD = v.rw; memtoregD = v.mtr; writeregD = v.wr;
        stallD = v.stall; flushE = v.flush;
        @(posedge clk);
        if (v.stall && expStall != 16'hFFFF) expStall++;
        if (v.flush && expFlush != 16'hFFFF) expFlush++;
        #1;
        s.rw = v.eRw; s.mtr = v.eMtr; s.tag = v.eTag;
        expQ.push_front(s);
        void'(expQ.pop_back());
        checkAll();
    endtask

    function automatic vec_t mk(input logic va, input logic rw, input logic mt, input logic [4:0] wr,
                                input logic st, input logic fl, input logic er, input logic em,
                                input logic [4:0] et);
        vec_t v;
        v.valid = va; v.rw = rw; v.mtr = mt; v.wr = wr; v.stall = st; v.flush = fl;
        v.eRw = er; v.eMtr = em; v.eTag = et;
        return v;
    endfunction

    task automatic doReset();
        rst = 1'b1;
        validD = 0; regwriteD = 0; memtoregD = 0; writeregD = '0; stallD = 0; flushE = 0;
        @(posedge clk); #1;
        clearModel();
        checkAll();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        doReset();
        for (int i = 0; i < 5; i++) step(idle);

        // valid, rw, mtr, wr, stall, flush  ->  expected E rw, mtr, tag
        vecs.push_back(mk(1, 1, 0, 3,  0, 0, 1, 0, 3));   // add r3
        vecs.push_back(mk(1, 1, 1, 5,  0, 0, 1, 1, 5));   // lw r5
        vecs.push_back(mk(1, 1, 0, 6,  1, 1, 0, 0, 0));   // load-use: stall+flush
        vecs.push_back(mk(1, 1, 0, 6,  0, 0, 1, 0, 6));   // dependent proceeds
        vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 0, 0));   // write to r0
        vecs.push_back(mk(1, 0, 1, 9,  0, 0, 0, 0, 0));   // load without regwrite
        vecs.push_back(mk(0, 1, 0, 4,  0, 0, 0, 0, 0));   // invalid slot
        vecs.push_back(mk(1, 1, 0, 8,  1, 0, 0, 0, 0));   // stall alone
        vecs.push_back(mk(1, 1, 1, 10, 0, 1, 0, 0, 0));   // flush alone
        vecs.push_back(mk(1, 1, 0, 31, 0, 0, 1, 0, 31));  // top register
        vecs.push_back(mk(1, 1, 1, 12, 0, 0, 1, 1, 12));
        vecs.push_back(mk(1, 1, 0, 12, 0, 0, 1, 0, 12));
        for (int i = 0; i < 4; i++) vecs.push_back(idle);
        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // add r3: pending[3] for exactly three cycles
        cnt = 0;
        step(mk(1, 1, 0, 3, 0, 0, 1, 0, 3));
        if (pending[3]) cnt++;
        for (int i = 0; i < 5; i++) begin
            step(idle);
            if (pending[3]) cnt++;
        end
        check("pend3_cycles", 32'(cnt), 32'd3);

        // three back-to-back writes to r7: pending[7] for five cycles
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(mk(1, 1, 0, 7, 0, 0, 1, 0, 7));
            if (pending[7]) cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            step(idle);
            if (pending[7]) cnt++;
        end
        check("pend7_cycles", 32'(cnt), 32'd5);

        // lw r5 held in M while E is bubbled
        doReset();
        step(mk(1, 1, 1, 5, 0, 0, 1, 1, 5));
        step(mk(1, 1, 0, 5, 1, 1, 0, 0, 0));
        check("lw_memtoregM", 32'(memtoregM), 32'd1);
        check("lw_writeregM", 32'(writeregM), 32'd5);
        check("lw_stall_cnt", 32'(stall_cnt), 32'd1);
        check("lw_flush_cnt", 32'(flush_cnt), 32'd1);

        // saturation
        validD = 0; regwriteD = 0; memtoregD = 0; writeregD = '0; stallD = 1; flushE = 1;
        for (int i = 0; i < 65536 + 5; i++) @(posedge clk);
        #1;
        check("sat_stall", 32'(stall_cnt), 32'h0000FFFF);
        check("sat_flush", 32'(flush_cnt), 32'h0000FFFF);
        @(posedge clk); #1;
        check("sat_hold", 32'(stall_cnt), 32'h0000FFFF);

        // mid-stream async reset drops in-flight tags at once
        stallD = 0; flushE = 0;
        validD = 1; regwriteD = 1; writeregD = 5'd12;
        @(posedge clk); #1;
        check("pre_rst_pending", pending, 32'h00001000);
        #2 rst = 1'b1;
        #1;
        check("rst_pending", pending, 32'd0);
        check("rst_writeregE", 32'(writeregE), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clearModel();
        step(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
